// File: rtl/cpu_sequencer.sv
// Push-button driven instruction sequencer: debounces a raw taster, latches an
// instruction word and steps it through DECODE/EXEC/WRITE with an EXEC timeout.
module cpu_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned EXEC_TIMEOUT    = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       taster,
  input  logic [7:0] sw,
  input  logic       alu_done,
  output logic [7:0] ir,
  output logic [1:0] rf_raddr_a,
  output logic [1:0] rf_raddr_b,
  output logic [2:0] alu_op,
  output logic       alu_go,
  output logic       rf_we,
  output logic [1:0] rf_waddr,
  output logic       busy,
  output logic       err,
  output logic [2:0] state,
  output logic [7:0] instr_count
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    WRITE  = 3'd3,
    ERROR  = 3'd4
  } state_e;

  state_e     state_q, state_d;
  logic       sync1_q, sync2_q;
  logic       deb_q, deb_d, deb_prev_q;
  logic [7:0] deb_cnt_q, deb_cnt_d;
  logic [7:0] tmo_q, tmo_d;
  logic [7:0] ir_q, ir_d;
  logic [7:0] cnt_q, cnt_d;
  logic       press;
  logic       active;

  // Counter restarts on any cycle where the synchronized input agrees with the debounced level.
  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (deb_cnt_q == 8'(DEBOUNCE_CYCLES - 1)) begin
        deb_d = sync2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 8'd1;
      end
    end
  end

  assign press = deb_q & ~deb_prev_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      deb_cnt_q  <= '0;
      state_q    <= IDLE;
      tmo_q      <= '0;
      ir_q       <= '0;
      cnt_q      <= '0;
    end else begin
      sync1_q    <= taster;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      deb_cnt_q  <= deb_cnt_d;
      state_q    <= state_d;
      tmo_q      <= tmo_d;
      ir_q       <= ir_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (press && enable) begin
          ir_d    = sw;
          state_d = DECODE;
        end
      end
      DECODE: begin
        tmo_d   = '0;
        state_d = EXEC;
      end
      EXEC: begin
        if (alu_done) begin
          state_d = WRITE;
        end else if (tmo_q == 8'(EXEC_TIMEOUT - 1)) begin
          state_d = ERROR;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      WRITE: begin
        cnt_d   = cnt_q + 8'd1;
        state_d = IDLE;
      end
      ERROR: begin
        if (press) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // tmo_q is zero only in the first EXEC cycle, which marks the start strobe.
  always_comb begin
    active     = (state_q == DECODE) || (state_q == EXEC) || (state_q == WRITE);
    rf_raddr_a = active ? ir_q[4:3] : '0;
    rf_raddr_b = active ? ir_q[2:1] : '0;
    alu_op     = active ? ir_q[7:5] : '0;
    alu_go     = (state_q == EXEC) && (tmo_q == '0);
    rf_we      = (state_q == WRITE) && (ir_q[7:5] != 3'b111);
    rf_waddr   = rf_we ? ir_q[4:3] : '0;
    busy       = (state_q != IDLE);
    err        = (state_q == ERROR);
    state      = state_q;
    ir         = ir_q;
    instr_count = cnt_q;
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: directed and randomized instructions
// checked against a transaction-level model of the expected timeline.
module tb_cpu_sequencer;
  localparam int DB = 16;
  localparam int TO = 16;
  localparam int PRESS_LAT = DB + 3;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       taster = 1'b0;
  logic [7:0] sw = '0;
  logic       alu_done = 1'b0;
  logic [7:0] ir;
  logic [1:0] rf_raddr_a, rf_raddr_b, rf_waddr;
  logic [2:0] alu_op, state;
  logic       alu_go, rf_we, busy, err;
  logic [7:0] instr_count;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_ir = '0;
  logic [7:0] exp_count = '0;

  cpu_sequencer #(.DEBOUNCE_CYCLES(DB), .EXEC_TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .enable(enable), .taster(taster), .sw(sw),
    .alu_done(alu_done), .ir(ir), .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
    .alu_op(alu_op), .alu_go(alu_go), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .busy(busy), .err(err), .state(state), .instr_count(instr_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic release_taster(input logic [2:0] hold_state);
    taster = 1'b0;
    for (int i = 0; i < PRESS_LAT + 3; i++) begin
      @(negedge clock);
      chk("release_hold", state, hold_state);
      chk("release_no_we", rf_we, 0);
    end
  endtask

  task automatic do_instr(input logic [7:0] w, input int dly, input bit en,
                          input bit bounce, input bit drop_en);
    logic [2:0] op;
    op = w[7:5];
    sw = w; enable = en; alu_done = 1'b0;
    if (bounce) begin
      for (int i = 0; i < 12; i++) begin
        taster = (i % 2 == 0);
        repeat (5) begin
          @(negedge clock);
          chk("bounce_idle", state, 0);
        end
      end
    end
    taster = 1'b1;
    for (int i = 0; i < PRESS_LAT - 1; i++) begin
      @(negedge clock);
      chk("wait_idle", state, 0);
      chk("wait_no_go", alu_go, 0);
    end
    @(negedge clock);
    if (!en) begin
      chk("dis_idle", state, 0);
      chk("dis_ir", ir, exp_ir);
      enable = 1'b1;
      repeat (3) @(negedge clock);
      chk("dis_no_queue", state, 0);
      release_taster(3'd0);
      return;
    end
    exp_ir = w;
    chk("dec_state", state, 1);
    chk("dec_busy", busy, 1);
    chk("dec_go", alu_go, 0);
    chk("dec_ir", ir, w);
    chk("dec_ra", rf_raddr_a, w[4:3]);
    chk("dec_rb", rf_raddr_b, w[2:1]);
    chk("dec_op", alu_op, op);
    if (drop_en) enable = 1'b0;
    for (int k = 0; k < TO; k++) begin
      @(negedge clock);
      chk("exec_state", state, 2);
      chk("exec_go", alu_go, (k == 0));
      chk("exec_op", alu_op, op);
      chk("exec_no_we", rf_we, 0);
      alu_done = (k >= dly);
      if (k >= dly) break;
    end
    @(negedge clock);
    alu_done = 1'b0;
    if (dly < TO) begin
      chk("wr_state", state, 3);
      chk("wr_we", rf_we, (op != 3'b111));
      chk("wr_waddr", rf_waddr, (op != 3'b111) ? w[4:3] : 2'd0);
      chk("wr_go", alu_go, 0);
      exp_count = exp_count + 8'd1;
      @(negedge clock);
      chk("done_idle", state, 0);
      chk("done_busy", busy, 0);
      chk("done_count", instr_count, exp_count);
      chk("done_op_zero", alu_op, 0);
      enable = 1'b1;
      release_taster(3'd0);
    end else begin
      chk("err_state", state, 4);
      chk("err_flag", err, 1);
      chk("err_busy", busy, 1);
      chk("err_ra_zero", rf_raddr_a, 0);
      chk("err_op_zero", alu_op, 0);
      for (int i = 0; i < 5; i++) begin
        enable = 1'($urandom);
        alu_done = 1'($urandom);
        @(negedge clock);
        chk("err_hold", state, 4);
      end
      alu_done = 1'b0;
      release_taster(3'd4);
      sw = ~w;
      enable = 1'($urandom);
      taster = 1'b1;
      for (int i = 0; i < PRESS_LAT - 1; i++) begin
        @(negedge clock);
        chk("err_wait", state, 4);
      end
      @(negedge clock);
      chk("err_exit_idle", state, 0);
      chk("err_exit_flag", err, 0);
      chk("err_exit_ir", ir, exp_ir);
      chk("err_exit_count", instr_count, exp_count);
      enable = 1'b1;
      release_taster(3'd0);
    end
    enable = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge clock);
    chk("rst_state", state, 0);
    chk("rst_ir", ir, 0);
    chk("rst_count", instr_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_we", rf_we, 0);
    reset = 1'b0;
    enable = 1'b1;

    do_instr(8'hB4, 0, 1'b1, 1'b0, 1'b0);
    chk("basic_count", instr_count, 1);
    do_instr(8'($urandom), 0, 1'b1, 1'b1, 1'b0);
    do_instr(8'hE0, 3, 1'b1, 1'b0, 1'b0);
    do_instr(8'h5A, TO, 1'b1, 1'b0, 1'b0);
    do_instr(8'h6C, 0, 1'b0, 1'b0, 1'b0);
    do_instr(8'h2E, 2, 1'b1, 1'b0, 1'b1);
    do_instr(8'h91, TO - 1, 1'b1, 1'b0, 1'b0);

    for (int n = 0; n < 30; n++) begin
      do_instr(8'($urandom), int'($urandom_range(0, 20)),
               ($urandom_range(0, 3) != 0), 1'b0, 1'($urandom));
    end

    sw = 8'($urandom); enable = 1'b1; alu_done = 1'b0; taster = 1'b1;
    repeat (PRESS_LAT + 1) @(negedge clock);
    chk("pre_rst_exec", state, 2);
    #2 reset = 1'b1;
    #1;
    chk("midrst_state", state, 0);
    chk("midrst_count", instr_count, 0);
    chk("midrst_ir", ir, 0);
    chk("midrst_we", rf_we, 0);
    chk("midrst_busy", busy, 0);
    taster = 1'b0;
    repeat (3) begin
      @(negedge clock);
      chk("midrst_hold_we", rf_we, 0);
    end
    reset = 1'b0;
    exp_count = '0;
    exp_ir = '0;
    for (int i = 0; i < PRESS_LAT + 4; i++) begin
      @(negedge clock);
      chk("postrst_idle", state, 0);
      chk("postrst_we", rf_we, 0);
    end

    for (int n = 0; n < 256; n++) begin
      do_instr(8'($urandom), int'($urandom_range(0, 2)), 1'b1, 1'b0, 1'b0);
    end
    chk("wrap_count", instr_count, exp_count);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 16, consecutive stable synchronized cycles needed to accept a new taster level (range 2..255).
REQ-002 Parameter: EXEC_TIMEOUT, default 16, maximum EXEC cycles to wait for alu_done before ERROR (range 1..255).
REQ-003 clock  in  1  single clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-005 enable  in  1  level; 0 blocks new instruction starts.
REQ-006 taster  in  1  raw push-button, asynchronous to clock, bouncing.
REQ-007 sw  in  8  instruction word: sw[7:5] opcode, sw[4:3] rd, sw[2:1] rs, sw[0] unused.
REQ-008 alu_done  in  1  datapath completion, sampled only in EXEC.
REQ-009 ir  out  8  latched instruction.
REQ-010 rf_raddr_a / rf_raddr_b  out  2 each  register read addresses, = ir[4:3] / ir[2:1] in every state except IDLE and ERROR, else 0.
REQ-011 alu_op  out  3  = ir[7:5] in every state except IDLE and ERROR, else 0.
REQ-012 alu_go  out  1  one-cycle start strobe.
REQ-013 rf_we  out  1  one-cycle write strobe; rf_waddr  out  2  = ir[4:3] while rf_we is 1, else 0.
REQ-014 busy  out  1  1 in every state except IDLE.
REQ-015 err  out  1  1 only in ERROR.
REQ-016 state  out  3  encoding IDLE=0, DECODE=1, EXEC=2, WRITE=3, ERROR=4.
REQ-017 instr_count  out  8  completed-instruction counter for display.

Function
REQ-018 taster shall pass through a 2-flop synchronizer; the debounced level shall change only after the synchronized value differs from it for DEBOUNCE_CYCLES consecutive cycles; any mismatch-free cycle restarts the count.
REQ-019 A press pulse shall be one cycle wide, on the cycle after the debounced level rises 0->1; release (1->0) shall produce no pulse.
REQ-020 IDLE: on press AND enable, ir <= sw and go to DECODE; press with enable=0 shall be discarded, never queued.
REQ-021 DECODE shall last exactly one cycle and go to EXEC.
REQ-022 alu_go shall be 1 only in the first EXEC cycle.
REQ-023 EXEC: alu_done=1 in any EXEC cycle, the first included, shall go to WRITE on the next edge.
REQ-024 EXEC timeout: after EXEC_TIMEOUT EXEC cycles with alu_done=0, the next state shall be ERROR; the timeout counter shall clear on EXEC entry.
REQ-025 WRITE shall last one cycle and return to IDLE.
REQ-026 In WRITE, rf_we shall be 1 unless opcode = 3'b111 (NOP).
REQ-027 In WRITE, instr_count shall increment by 1 whether or not rf_we is 1, wrapping 255->0.
REQ-028 ERROR: hold until a press pulse, then go to IDLE without loading ir; enable is ignored in ERROR.
REQ-029 Press pulses outside IDLE/ERROR shall be ignored.
REQ-030 alu_done outside EXEC shall be ignored.
REQ-031 enable falling mid-instruction shall not abort the instruction; it completes normally to IDLE.
REQ-032 Minimum latency, press pulse at cycle N with alu_done=1 at once: DECODE N+1, EXEC N+2 (alu_go), WRITE N+3 (rf_we), IDLE N+4.

Reset
REQ-033 While reset=1, all outputs and the following shall be 0: state (IDLE), ir, instr_count, synchronizer, debounced level, debounce and timeout counters.
REQ-034 Reset mid-instruction shall abort with no rf_we pulse.
REQ-035 Press detection shall need a fresh 0->1 debounced transition after reset deasserts.

Verification
REQ-036 Defaults, enable=1, sw=8'hB4 (op=5, rd=2, rs=2), taster held high 20 cycles, alu_done=1 tied -> exactly one alu_go, one rf_we with rf_waddr=2, alu_op=5, ir=8'hB4, instr_count=1.
REQ-037 taster toggled every 5 cycles for 60 cycles, then held high -> no press until 16 stable cycles; exactly one instruction executed.
REQ-038 sw=8'hE0 (NOP), alu_done after 3 EXEC cycles -> WRITE with rf_we=0; instr_count increments.
REQ-039 alu_done held 0 -> ERROR (state=4, err=1) after 16 EXEC cycles; next press -> IDLE, ir unchanged.
REQ-040 enable=0 plus press -> stays IDLE; reset asserted during EXEC -> state=0, instr_count=0 immediately, no rf_we.
REQ-041 256 instructions run back-to-back -> instr_count wraps to 0.
